// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core run/step/halt sequencer.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        StPause,
        StRun,
        StStep,
        StDone,
        StTimeout
    } state_e;

    typedef enum logic [1:0] {
        StatusPause   = 2'b00,
        StatusRun     = 2'b01,
        StatusDone    = 2'b10,
        StatusTimeout = 2'b11
    } status_e;

    localparam int unsigned DefCeDiv     = 10;
    localparam int unsigned DefRstHold   = 16;
    localparam int unsigned DefMaxCycles = 1_000_000;

    function automatic status_e status_of(state_e s);
        status_e st;
        case (s)
            StRun, StStep: st = StatusRun;
            StDone:        st = StatusDone;
            StTimeout:     st = StatusTimeout;
            default:       st = StatusPause;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Button/halt inputs and core-control outputs of the run controller.
interface core_run_ctrl_if;

    logic        btn_run;
    logic        btn_step;
    logic        btn_clear;
    logic        hlt;
    logic [31:0] result_in;
    logic        core_ce;
    logic        core_rst;
    logic [31:0] result_q;
    logic        result_valid;
    logic [31:0] cycle_cnt;
    logic [1:0]  status;

    modport master (
        output btn_run, btn_step, btn_clear, hlt, result_in,
        input  core_ce, core_rst, result_q, result_valid, cycle_cnt, status
    );

    modport slave (
        input  btn_run, btn_step, btn_clear, hlt, result_in,
        output core_ce, core_rst, result_q, result_valid, cycle_cnt, status
    );

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw button followed by a registered rising-edge pulse.
module btn_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pe_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       pe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            prev_q <= sync_q[1];
            pe_q   <= sync_q[1] & ~prev_q;
        end
    end

    assign pe_o = pe_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/halt sequencer: gates the core with a one-cycle clock enable, holds core reset,
// counts issued core cycles and captures the halted result.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned CE_DIV     = DefCeDiv,
    parameter int unsigned RST_HOLD   = DefRstHold,
    parameter int unsigned MAX_CYCLES = DefMaxCycles
) (
    input logic            clk_100MHz,
    input logic            reset,
    core_run_ctrl_if.slave bus
);

    localparam int unsigned PrescW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int unsigned HoldW  = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(CE_DIV - 1);

    logic run_pe, step_pe, clear_pe;

    btn_edge u_run_edge (
        .clk_i (clk_100MHz),
        .rst_ni(reset),
        .btn_i (bus.btn_run),
        .pe_o  (run_pe)
    );

    btn_edge u_step_edge (
        .clk_i (clk_100MHz),
        .rst_ni(reset),
        .btn_i (bus.btn_step),
        .pe_o  (step_pe)
    );

    btn_edge u_clear_edge (
        .clk_i (clk_100MHz),
        .rst_ni(reset),
        .btn_i (bus.btn_clear),
        .pe_o  (clear_pe)
    );

    state_e            state_q, state_d;
    status_e           status_q;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              core_rst_q, core_rst_d;
    logic              core_ce_q, core_ce_d;
    logic [31:0]       result_q, result_d;
    logic              valid_q, valid_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       cnt_inc;
    logic              run_go, step_go, clear_go;

    // Buttons are meaningless while the core itself is held in reset.
    assign run_go   = run_pe & ~core_rst_q;
    assign step_go  = step_pe & ~core_rst_q;
    assign clear_go = clear_pe & ~core_rst_q;
    assign cnt_inc  = (cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        hold_d     = (hold_q != '0) ? hold_q - HoldW'(1) : hold_q;
        core_rst_d = (hold_d != '0);
        core_ce_d  = 1'b0;
        result_d   = result_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;

        if (clear_go) begin
            state_d    = StPause;
            hold_d     = HoldW'(RST_HOLD);
            core_rst_d = 1'b1;
            cnt_d      = '0;
            valid_d    = 1'b0;
            presc_d    = '0;
        end else if (bus.hlt && (state_q inside {StPause, StRun, StStep})) begin
            state_d  = StDone;
            result_d = bus.result_in;
            valid_d  = 1'b1;
        end else begin
            case (state_q)
                StPause: begin
                    if (run_go) begin
                        state_d = StRun;
                        presc_d = '0;
                    end else if (step_go) begin
                        state_d = StStep;
                    end
                end
                StRun: begin
                    if (run_go) begin
                        state_d = StPause;
                        presc_d = '0;
                    end else if (cnt_q >= MAX_CYCLES) begin
                        state_d  = StTimeout;
                        result_d = bus.result_in;
                    end else if (presc_q == PrescLast) begin
                        presc_d   = '0;
                        core_ce_d = 1'b1;
                        cnt_d     = cnt_inc;
                    end else begin
                        presc_d = presc_q + PrescW'(1);
                    end
                end
                StStep: begin
                    core_ce_d = 1'b1;
                    cnt_d     = cnt_inc;
                    state_d   = StPause;
                end
                StDone, StTimeout: ;
                default: state_d = StPause;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= StPause;
            status_q   <= StatusPause;
            presc_q    <= '0;
            hold_q     <= HoldW'(RST_HOLD);
            core_rst_q <= 1'b1;
            core_ce_q  <= 1'b0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_of(state_d);
            presc_q    <= presc_d;
            hold_q     <= hold_d;
            core_rst_q <= core_rst_d;
            core_ce_q  <= core_ce_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.core_ce      = core_ce_q;
    assign bus.core_rst     = core_rst_q;
    assign bus.result_q     = result_q;
    assign bus.result_valid = valid_q;
    assign bus.cycle_cnt    = cnt_q;
    assign bus.status       = status_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: event-time reference model checked every cycle, plus literal checks.
module tb_core_run_ctrl;

    localparam int CeDiv   = 10;
    localparam int RstHold = 16;
    localparam int MaxCyc  = 20;

    localparam int ModePause   = 0;
    localparam int ModeRun     = 1;
    localparam int ModeStep    = 2;
    localparam int ModeDone    = 3;
    localparam int ModeTimeout = 4;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    core_run_ctrl_if bus ();

    core_run_ctrl #(
        .CE_DIV    (CeDiv),
        .RST_HOLD  (RstHold),
        .MAX_CYCLES(MaxCyc)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clock edges counted from reset release; button effects scheduled by
    // edge number; RUN pulses fall on every CeDiv-th edge after RUN entry.
    int          m_n, m_hold_end, m_run_start, m_mode;
    int          ev_run, ev_step, ev_clear;
    logic        m_ce, m_valid;
    logic [31:0] m_cnt, m_res;

    function automatic logic [1:0] mode_status(input int mode);
        if (mode == ModeRun || mode == ModeStep) return 2'b01;
        if (mode == ModeDone) return 2'b10;
        if (mode == ModeTimeout) return 2'b11;
        return 2'b00;
    endfunction

    task automatic m_reset();
        m_n = 0; m_hold_end = RstHold; m_run_start = 0; m_mode = ModePause;
        ev_run = -1; ev_step = -1; ev_clear = -1;
        m_ce = 1'b0; m_valid = 1'b0; m_cnt = '0; m_res = '0;
    endtask

    task automatic m_edge();
        bit busy, clr, run, stp;
        m_n++;
        busy = (m_n - 1) < m_hold_end;
        clr  = !busy && (ev_clear == m_n);
        run  = !busy && (ev_run == m_n);
        stp  = !busy && (ev_step == m_n);
        m_ce = 1'b0;
        if (clr) begin
            m_mode = ModePause; m_hold_end = m_n + RstHold; m_cnt = '0; m_valid = 1'b0;
        end else if (bus.hlt && m_mode <= ModeStep) begin
            m_res = bus.result_in; m_valid = 1'b1; m_mode = ModeDone;
        end else if (m_mode == ModePause) begin
            if (run) begin
                m_mode = ModeRun; m_run_start = m_n;
            end else if (stp) begin
                m_mode = ModeStep;
            end
        end else if (m_mode == ModeRun) begin
            if (run) m_mode = ModePause;
            else if (m_cnt >= MaxCyc) begin
                m_mode = ModeTimeout; m_res = bus.result_in;
            end else if ((m_n - m_run_start) % CeDiv == 0) begin
                m_ce = 1'b1;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
        end else if (m_mode == ModeStep) begin
            m_ce = 1'b1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            m_mode = ModePause;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_100MHz or negedge reset);
            if (!reset) m_reset();
            else m_edge();
        end
    end

    initial begin
        @(negedge clk_100MHz);
        forever begin
            @(negedge clk_100MHz);
            chk("core_ce", bus.core_ce, m_ce);
            chk("core_rst", bus.core_rst, (m_n < m_hold_end));
            chk("result_q", bus.result_q, m_res);
            chk("result_valid", bus.result_valid, m_valid);
            chk("cycle_cnt", bus.cycle_cnt, m_cnt);
            chk("status", bus.status, mode_status(m_mode));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "bench time limit");
    end

    // Called at a negedge; which: 0 run, 1 step, 2 clear. Effect lands 4 edges later.
    task automatic press(input int which);
        if (which == 0) begin ev_run = m_n + 4; bus.btn_run = 1'b1; end
        else if (which == 1) begin ev_step = m_n + 4; bus.btn_step = 1'b1; end
        else begin ev_clear = m_n + 4; bus.btn_clear = 1'b1; end
        repeat (3) @(negedge clk_100MHz);
        bus.btn_run = 1'b0; bus.btn_step = 1'b0; bus.btn_clear = 1'b0;
        repeat (2) @(negedge clk_100MHz);
    endtask

    task automatic wait_to(input int target);
        while (m_n < target) @(negedge clk_100MHz);
    endtask

    int e, c;

    initial begin
        bus.btn_run = 1'b0; bus.btn_step = 1'b0; bus.btn_clear = 1'b0;
        bus.hlt = 1'b0; bus.result_in = '0;
        repeat (3) @(negedge clk_100MHz);
        chk("rst core_rst", bus.core_rst, 1'b1);
        chk("rst status", bus.status, 2'b00);
        chk("rst cycle_cnt", bus.cycle_cnt, 32'd0);
        reset = 1'b1;
        @(negedge clk_100MHz);
        press(0);  // lands during core reset hold: ignored
        wait_to(15);
        chk("hold still high", bus.core_rst, 1'b1);
        wait_to(16);
        chk("hold released", bus.core_rst, 1'b0);
        chk("run ignored in hold", bus.status, 2'b00);

        // Free run at CeDiv, then pause
        wait_to(20);
        e = m_n + 4;
        press(0);
        wait_to(e + 50);
        chk("run 50 cnt", bus.cycle_cnt, 32'd5);
        chk("run status", bus.status, 2'b01);
        press(0);
        wait_to(e + 80);
        chk("pause cnt", bus.cycle_cnt, 32'd5);
        chk("pause status", bus.status, 2'b00);

        // Clear then single steps
        c = m_n;
        press(2);
        chk("clear core_rst", bus.core_rst, 1'b1);
        wait_to(c + 4 + RstHold + 2);
        chk("clear cnt", bus.cycle_cnt, 32'd0);
        press(1);
        wait_to(m_n + 2);
        chk("step1 cnt", bus.cycle_cnt, 32'd1);
        chk("step1 status", bus.status, 2'b00);
        press(1);
        press(1);
        wait_to(m_n + 2);
        chk("step3 cnt", bus.cycle_cnt, 32'd3);

        // Halt in RUN on the edge that would have pulsed
        e = m_n + 4;
        press(0);
        wait_to(e + 29);
        bus.hlt = 1'b1; bus.result_in = 32'h0000_1234;
        @(negedge clk_100MHz);
        bus.hlt = 1'b0;
        chk("hlt ce blocked", bus.core_ce, 1'b0);
        chk("hlt result", bus.result_q, 32'h0000_1234);
        chk("hlt valid", bus.result_valid, 1'b1);
        chk("hlt status", bus.status, 2'b10);
        press(0);
        press(1);
        wait_to(m_n + 12);
        chk("done holds status", bus.status, 2'b10);
        chk("done holds cnt", bus.cycle_cnt, 32'd5);

        // Watchdog timeout
        c = m_n;
        press(2);
        wait_to(c + 4 + RstHold + 2);
        bus.result_in = 32'hCAFE_0001;
        e = m_n + 4;
        press(0);
        wait_to(e + 200);
        chk("pre-timeout status", bus.status, 2'b01);
        chk("pre-timeout cnt", bus.cycle_cnt, 32'd20);
        wait_to(e + 201);
        chk("timeout status", bus.status, 2'b11);
        chk("timeout valid", bus.result_valid, 1'b0);
        chk("timeout result", bus.result_q, 32'hCAFE_0001);

        // Clear and halt on the same edge: clear wins
        c = m_n;
        press(2);
        wait_to(c + 4 + RstHold + 2);
        e = m_n + 4;
        press(0);
        wait_to(e + 25);
        c = m_n;
        ev_clear = c + 4;
        bus.btn_clear = 1'b1;
        wait_to(c + 3);
        bus.hlt = 1'b1;
        @(negedge clk_100MHz);
        bus.hlt = 1'b0;
        bus.btn_clear = 1'b0;
        chk("clr+hlt core_rst", bus.core_rst, 1'b1);
        chk("clr+hlt cnt", bus.cycle_cnt, 32'd0);
        chk("clr+hlt status", bus.status, 2'b00);
        chk("clr+hlt valid", bus.result_valid, 1'b0);
        chk("clr+hlt result kept", bus.result_q, 32'hCAFE_0001);

        // Async reset in the middle of RUN
        wait_to(c + 4 + RstHold + 2);
        bus.result_in = '0;
        e = m_n + 4;
        press(0);
        wait_to(e + 25);
        chk("pre-reset status", bus.status, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        chk("async core_ce", bus.core_ce, 1'b0);
        chk("async core_rst", bus.core_rst, 1'b1);
        chk("async result", bus.result_q, 32'd0);
        chk("async valid", bus.result_valid, 1'b0);
        chk("async cnt", bus.cycle_cnt, 32'd0);
        chk("async status", bus.status, 2'b00);
        @(negedge clk_100MHz);
        reset = 1'b1;
        repeat (20) @(negedge clk_100MHz);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
